dr32e_dmem_ctrl: RTL and testbench
==================================

# dr32e_dmem_ctrl

Data-memory controller on the slave side of the LSU data interface. Accepts the LSU's req/gnt/rvalid transactions, checks each address against the mapped window and drives a single-port, one-cycle-latency SRAM macro. Returns read data or write acknowledgement with a bus-error flag, one transaction in flight at a time, with back-to-back issue allowed.

## Interface
- `MemDataWidth`, 32: data bus and SRAM word width.
- `BaseAddr`, 32'h0001_0000: byte address of SRAM word 0; must be 4-byte aligned.
- `MemWords`, 4096: SRAM depth in words, power of two. `AddrW = $clog2(MemWords)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `data_req_i`  in  1  LSU request; held until granted.
- `data_addr_i`  in  32  byte address.
- `data_we_i`  in  1  1 = store.
- `data_be_i`  in  4  byte enables.
- `data_wdata_i`  in  MemDataWidth  store data.
- `data_gnt_o`  out  1  request accepted this cycle.
- `data_rvalid_o`  out  1  response valid; one pulse per granted request.
- `data_rdata_o`  out  MemDataWidth  load data; 0 for stores and errors.
- `data_bus_err_o`  out  1  qualified by `data_rvalid_o`.
- `sram_req_o`  out  1  SRAM access strobe.
- `sram_we_o`  out  1  SRAM write.
- `sram_addr_o`  out  AddrW  word index.
- `sram_wmask_o`  out  MemDataWidth  bit mask expanded from `data_be_i`.
- `sram_wdata_o`  out  MemDataWidth  write data.
- `sram_rdata_i`  in  MemDataWidth  read data, valid the cycle after `sram_req_o`.
- `stall_cycles_i`  in  4  grant delay; present only with `DR32E_DMEM_STALL_EN`.

## Operation
- Address check:
  - `hit = (data_addr_i - BaseAddr) < MemWords*4`, computed as a 32-bit unsigned subtract; wraps below `BaseAddr` produce a miss.
  - Word index = `(data_addr_i - BaseAddr)[AddrW+1:2]`.
  - Low two address bits are ignored; the LSU splits misaligned accesses.
- Grant cycle (`data_req_i && data_gnt_o`):
  - A hit drives `sram_req_o` = 1 with `sram_we_o = data_we_i`.
  - A miss drives `sram_req_o` = 0, so a faulting store never writes.
  - `data_be_i` = 0 on a store: the access is granted, the SRAM is not written, and the response has no error.
- Response register, captured at grant: `pend_q`, `we_q`, `err_q`.
- Next cycle:
  - `data_rvalid_o = pend_q`, `data_bus_err_o = pend_q & err_q`.
  - `data_rdata_o = (pend_q & ~we_q & ~err_q) ? sram_rdata_i : 0`.
- FSM states:
  - IDLE to STALL when a request is seen and the stall count is non-zero.
  - STALL counts down, then returns to IDLE with grant.
  - Without stall, grant is issued in IDLE.
- Back-to-back: a new grant may coincide with `data_rvalid_o` of the previous access.
- A request dropped before grant violates the protocol; behaviour is undefined, and an assertion flags it.

## Timing
- Reset values: every output is 0, `pend_q` = 0, FSM = IDLE, stall counter = 0.
- Grant latency: 0 cycles (combinational `data_gnt_o = data_req_i`) without stall; N cycles with `stall_cycles_i` = N.
- Response latency: exactly 1 cycle after grant, for both hit and miss.
- Throughput: 1 access/cycle with no stall.
- Reset asserted mid-transaction drops the pending response: no `data_rvalid_o` follows reset.
- A grant coincident with the reset cycle is ignored.

## Configuration
- `DR32E_DMEM_STALL_EN` defined:
  - The `stall_cycles_i` port and a 4-bit down-counter are present.
  - The counter samples `stall_cycles_i` on the first cycle `data_req_i` is seen in IDLE.
  - `data_gnt_o` asserts when the counter reaches 0.
  - The sampled value holds for the whole request; a changing input has no effect until the next request.
- Not defined: no port, no counter, zero-wait grant; the STALL state is not generated.

## Structure
- Package `dr32e_dmem_pkg`:
  - FSM state enum `dmem_state_e` (IDLE, STALL).
  - Default `BaseAddr` constant.
  - Function `be_to_mask` (4 bits to MemDataWidth bits).
- Sub-module `dr32e_dmem_stall`: stall counter and grant gating, instantiated only under the macro.
- The SRAM macro is external.

## Test plan
- Store 32'hDEADBEEF to 0x0001_0010 with be=4'hF, then load the same address: the load gets `gnt` in the request cycle, `rvalid` one cycle later, rdata = 32'hDEADBEEF, err = 0.
- Store 32'h0000_00AA with be=4'b0001 over 32'h11223344 at 0x0001_0020, then load: rdata = 32'h112233AA.
- Load from 0x0000_FFFC and from 0x0001_4000: err = 1, rdata = 0, `sram_req_o` never asserted. A store to 0x0001_4000 leaves word 0 unchanged.
- Back-to-back: 4 loads with `req` held high for 4 cycles produce 4 consecutive grants and 4 consecutive `rvalid` pulses in order.
- With `DR32E_DMEM_STALL_EN` and stall=3: the grant arrives 3 cycles after `req` rises and `rvalid` the cycle after. With stall=0, the grant is same-cycle.
- Reset pulsed the cycle after a grant: no `rvalid` appears, all outputs read 0, and the next load completes normally.

Source files
------------

// File: rtl/dr32e_dmem_pkg.sv
// dr32e_dmem_pkg: shared types, constants and helpers for the data-memory controller.
// The optional grant-stall feature is enabled with the DR32E_DMEM_STALL_EN macro.
`timescale 1ns/1ps
package dr32e_dmem_pkg;

    // Grant FSM: IDLE issues zero-wait grants, STALL counts down a sampled delay.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } dmem_state_e;

    // Default byte address of SRAM word 0 (4-byte aligned).
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0001_0000;

    // Native data width of the byte-enable expansion below.
    localparam int unsigned DMEM_DW = 32;

    // Expand 4 byte enables into a per-bit write mask, one lane per quarter word.
    function automatic logic [DMEM_DW-1:0] be_to_mask(input logic [3:0] be);
        logic [DMEM_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*(DMEM_DW/4) +: (DMEM_DW/4)] = {(DMEM_DW/4){be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dr32e_dmem_stall.sv
// dr32e_dmem_stall: grant-delay FSM, only instantiated when DR32E_DMEM_STALL_EN is defined.
// Samples the stall count on the first request cycle seen in IDLE and holds it
// for the whole request, so later changes of stall_cycles_i are ignored.
`timescale 1ns/1ps
module dr32e_dmem_stall
    import dr32e_dmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [3:0] stall_cycles_i,
    output logic       gnt_o
);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter is loaded with N-1 so the grant lands N cycles after req rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (stall_cycles_i == 4'd0) begin
                        gnt_o = 1'b1;
                    end else begin
                        cnt_d   = stall_cycles_i - 4'd1;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (cnt_q == 4'd0) begin
                    gnt_o   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/dr32e_dmem_ctrl.sv
// dr32e_dmem_ctrl: LSU-slave data-memory controller driving a 1-cycle-latency SRAM.
// Define DR32E_DMEM_STALL_EN to add the stall_cycles_i port and grant-delay counter.
`timescale 1ns/1ps
module dr32e_dmem_ctrl
    import dr32e_dmem_pkg::*;
#(
    parameter int unsigned MemDataWidth = 32,
    parameter logic [31:0] BaseAddr     = DMEM_BASE_ADDR,
    parameter int unsigned MemWords     = 4096,
    localparam int unsigned AddrW       = $clog2(MemWords)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_req_i,
    input  logic [31:0]             data_addr_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [MemDataWidth-1:0] data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [MemDataWidth-1:0] data_rdata_o,
    output logic                    data_bus_err_o,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [AddrW-1:0]        sram_addr_o,
    output logic [MemDataWidth-1:0] sram_wmask_o,
    output logic [MemDataWidth-1:0] sram_wdata_o,
    input  logic [MemDataWidth-1:0] sram_rdata_i
`ifdef DR32E_DMEM_STALL_EN
    ,
    input  logic [3:0]              stall_cycles_i
`endif
);

    localparam logic [31:0] WindowBytes = 32'(MemWords * 4);

    logic [31:0] offset;
    logic        hit;
    logic        gnt;
    logic        access;
    logic        store;
    logic        pend_q, pend_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        unused_offset_bits;

    // Unsigned subtract: addresses below the base wrap to huge offsets and miss.
    assign offset = data_addr_i - BaseAddr;
    assign hit    = (offset < WindowBytes);

    // Byte-lane bits and bits above the window never select a word.
    assign unused_offset_bits = ^{offset[31:AddrW+2], offset[1:0]};

`ifdef DR32E_DMEM_STALL_EN
    logic stall_gnt;

    dr32e_dmem_stall u_stall (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (data_req_i),
        .stall_cycles_i (stall_cycles_i),
        .gnt_o          (stall_gnt)
    );

    assign gnt = data_req_i & ~rst_i & stall_gnt;
`else
    assign gnt = data_req_i & ~rst_i;
`endif

    // Only a granted in-window access touches the SRAM; a faulting store never writes.
    assign access       = gnt & hit;
    assign store        = access & data_we_i;
    assign data_gnt_o   = gnt;
    assign sram_req_o   = access;
    assign sram_we_o    = store;
    assign sram_addr_o  = access ? offset[AddrW+1:2] : '0;
    assign sram_wmask_o = store ? MemDataWidth'(be_to_mask(data_be_i)) : '0;
    assign sram_wdata_o = store ? data_wdata_i : '0;

    assign pend_d = gnt;
    assign we_d   = data_we_i;
    assign err_d  = ~hit;

    // Response register captured at grant; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            we_q   <= we_d;
            err_q  <= err_d;
        end
    end

    // Responses are masked during reset so every output reads 0 while it is held.
    assign data_rvalid_o  = pend_q & ~rst_i;
    assign data_bus_err_o = pend_q & err_q & ~rst_i;
    assign data_rdata_o   = (pend_q & ~we_q & ~err_q & ~rst_i) ? sram_rdata_i : '0;

    // The LSU must hold a request until it is granted.
    req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (data_req_i && !data_gnt_o) |=> data_req_i);

endmodule

// File: tb/tb_dr32e_dmem_ctrl.sv
// tb_dr32e_dmem_ctrl: self-checking bench with a vector table, hand-written corner
// sequences and a randomized stream checked against a word-array reference model.
`timescale 1ns/1ps
module tb_dr32e_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = 4096;
    localparam int          AW    = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, bus_err;
    logic [31:0] rdata;
    logic        sram_req, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_wmask, sram_wdata;
    logic [31:0] sram_rdata;
`ifdef DR32E_DMEM_STALL_EN
    logic [3:0]  stall = 4'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dr32e_dmem_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_req_i     (req),
        .data_addr_i    (addr),
        .data_we_i      (we),
        .data_be_i      (be),
        .data_wdata_i   (wdata),
        .data_gnt_o     (gnt),
        .data_rvalid_o  (rvalid),
        .data_rdata_o   (rdata),
        .data_bus_err_o (bus_err),
        .sram_req_o     (sram_req),
        .sram_we_o      (sram_we),
        .sram_addr_o    (sram_addr),
        .sram_wmask_o   (sram_wmask),
        .sram_wdata_o   (sram_wdata),
        .sram_rdata_i   (sram_rdata)
`ifdef DR32E_DMEM_STALL_EN
        ,
        .stall_cycles_i (stall)
`endif
    );

    // External SRAM macro: masked write, registered read.
    logic [31:0] sram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we)
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else
                sram_rdata <= sram_mem[sram_addr];
        end
    end

    // Reference model: byte-addressed window over a plain word array.
    logic [31:0] ref_mem [0:WORDS-1];

    task automatic ref_access(input logic r_we, input logic [31:0] r_addr, input logic [3:0] r_be,
                              input logic [31:0] r_wdata, output logic r_err, output logic [31:0] r_rdata);
        longint unsigned a;
        int idx;
        a = longint'(r_addr);
        r_err   = 1'b0;
        r_rdata = '0;
        if (a < longint'(BASE) || a >= longint'(BASE) + longint'(WORDS) * 4) begin
            r_err = 1'b1;
        end else begin
            idx = int'((a - longint'(BASE)) / 4);
            if (r_we) begin
                for (int b = 0; b < 4; b++)
                    if (r_be[b]) ref_mem[idx][b*8 +: 8] = r_wdata[b*8 +: 8];
            end else begin
                r_rdata = ref_mem[idx];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Outputs that must all be zero while idle or held in reset.
    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
        check({tag, ".rdata"}, rdata, 32'd0);
        check({tag, ".err"}, 32'(bus_err), 32'd0);
        check({tag, ".sram_req"}, 32'(sram_req), 32'd0);
        check({tag, ".sram_we"}, 32'(sram_we), 32'd0);
        check({tag, ".sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, ".sram_wmask"}, sram_wmask, 32'd0);
        check({tag, ".sram_wdata"}, sram_wdata, 32'd0);
    endtask

    // One isolated transaction; entered and left at posedge+1 with inputs idle.
    task automatic single_xact(input string tag, input logic t_we, input logic [31:0] t_addr,
                               input logic [3:0] t_be, input logic [31:0] t_wdata,
                               input logic exp_err, input logic [31:0] exp_rdata);
        req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata;
        @(negedge clk);
        check({tag, ".gnt"}, 32'(gnt), 32'd1);
        check({tag, ".sram_req"}, 32'(sram_req), 32'(!exp_err));
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        @(negedge clk);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check({tag, ".err"}, 32'(bus_err), 32'(exp_err));
        check({tag, ".rdata"}, rdata, exp_rdata);
        $display("[TB] %s we=%0d addr=%h be=%h wdata=%h -> err=%0d rdata=%h",
                 tag, t_we, t_addr, t_be, t_wdata, bus_err, rdata);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic        m_err;
        logic [31:0] m_rdata;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp  [4];
        logic        prev_valid, prev_err;
        logic [31:0] prev_rdata;

        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        vecs[0]  = '{1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0001_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0001_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0001_0020, 4'h1, 32'h0000_00AA, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0001_0020, 4'hF, 32'h0,         1'b0, 32'h1122_33AA};
        vecs[5]  = '{1'b1, 32'h0001_0000, 4'hF, 32'h5566_7788, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_FFFC, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0001_4000, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'h0001_4000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         1'b0, 32'h5566_7788};
        vecs[10] = '{1'b1, 32'h0001_0000, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0001_0003, 4'hF, 32'h0,         1'b0, 32'h5566_7788};
        vecs[12] = '{1'b1, 32'h0001_3FFC, 4'hC, 32'hA5A5_0000, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0001_3FFC, 4'hF, 32'h0,         1'b0, 32'hA5A5_0000};
        vecs[14] = '{1'b1, 32'h0001_0000, 4'h6, 32'h00CC_DD00, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         1'b0, 32'h55CC_DD88};

        // Reset state, both while held and after release.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset_held");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");
        @(posedge clk); #1;

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            single_xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be,
                        vecs[i].wdata, vecs[i].err, vecs[i].rdata);
            ref_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, m_err, m_rdata);
        end

        // Back-to-back loads with req held for four cycles.
        b2b_addr = '{32'h0001_0010, 32'h0001_0020, 32'h0001_0000, 32'h0001_3FFC};
        b2b_exp  = '{32'hDEAD_BEEF, 32'h1122_33AA, 32'h55CC_DD88, 32'hA5A5_0000};
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; we = 1'b0; be = 4'hF; addr = b2b_addr[i];
            @(negedge clk);
            check($sformatf("b2b%0d.gnt", i), 32'(gnt), 32'd1);
            check($sformatf("b2b%0d.rvalid", i), 32'(rvalid), 32'(i > 0));
            if (i > 0) begin
                check($sformatf("b2b%0d.rdata", i - 1), rdata, b2b_exp[i-1]);
                $display("[TB] b2b%0d load addr=%h -> rdata=%h", i - 1, b2b_addr[i-1], rdata);
            end
            @(posedge clk); #1;
        end
        req = 1'b0; be = '0; addr = '0;
        @(negedge clk);
        check("b2b3.rvalid", 32'(rvalid), 32'd1);
        check("b2b3.rdata", rdata, b2b_exp[3]);
        $display("[TB] b2b3 load addr=%h -> rdata=%h", b2b_addr[3], rdata);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_tail.rvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;

        // Reset pulsed the cycle after a grant drops the response.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0001_0010;
        @(negedge clk);
        check("rst_mid.gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; be = '0; addr = '0; rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid.in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.after.rvalid", 32'(rvalid), 32'd0);
        $display("[TB] rst_mid load addr=00010010 dropped by reset");
        @(posedge clk); #1;

        // A request coincident with reset is not granted and yields no response.
        rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0001_0010;
        @(negedge clk);
        check("rst_req.gnt", 32'(gnt), 32'd0);
        check("rst_req.sram_req", 32'(sram_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; be = '0; addr = '0;
        @(negedge clk);
        check("rst_req.rvalid", 32'(rvalid), 32'd0);
        $display("[TB] rst_req load addr=00010010 ignored during reset");
        @(posedge clk); #1;
        single_xact("post_reset", 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);

`ifdef DR32E_DMEM_STALL_EN
        // Stall of 3: grant three cycles after req rises; input change mid-request ignored.
        stall = 4'd3; req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0001_0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall3.wait%0d.gnt", k), 32'(gnt), 32'd0);
            check($sformatf("stall3.wait%0d.sram_req", k), 32'(sram_req), 32'd0);
            check($sformatf("stall3.wait%0d.rvalid", k), 32'(rvalid), 32'd0);
            @(posedge clk); #1;
            if (k == 0) stall = 4'd9;
        end
        @(negedge clk);
        check("stall3.gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; be = '0; addr = '0; stall = 4'd0;
        @(negedge clk);
        check("stall3.rvalid", 32'(rvalid), 32'd1);
        check("stall3.rdata", rdata, 32'hDEAD_BEEF);
        $display("[TB] stall3 load addr=00010010 -> rdata=%h", rdata);
        @(posedge clk); #1;
        single_xact("stall0", 1'b0, 32'h0001_0020, 4'hF, 32'h0, 1'b0, 32'h1122_33AA);
`endif

        // Randomized stream with back-to-back issue against the reference model.
        prev_valid = 1'b0; prev_err = 1'b0; prev_rdata = '0;
        for (int n = 0; n < 300; n++) begin
            logic        go;
            logic        cur_err;
            logic [31:0] cur_rdata;
            int          sel;
            go = ($urandom_range(0, 3) != 0);
            cur_err = 1'b0; cur_rdata = '0;
            if (go) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 6)
                    addr = BASE + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
                else if (sel == 6)
                    addr = BASE + 32'($urandom_range(0, WORDS * 4 - 1));
                else if (sel == 7)
                    addr = BASE - 32'($urandom_range(1, 64));
                else if (sel == 8)
                    addr = BASE + 32'(WORDS * 4) + 32'($urandom_range(0, 64));
                else
                    addr = $urandom();
                req   = 1'b1;
                we    = 1'($urandom_range(0, 1));
                be    = 4'($urandom_range(0, 15));
                wdata = $urandom();
                ref_access(we, addr, be, wdata, cur_err, cur_rdata);
            end else begin
                req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
            end
            @(negedge clk);
            check($sformatf("rnd%0d.gnt", n), 32'(gnt), 32'(go));
            if (go) check($sformatf("rnd%0d.sram_req", n), 32'(sram_req), 32'(!cur_err));
            check($sformatf("rnd%0d.rvalid", n), 32'(rvalid), 32'(prev_valid));
            if (prev_valid) begin
                check($sformatf("rnd%0d.err", n), 32'(bus_err), 32'(prev_err));
                check($sformatf("rnd%0d.rdata", n), rdata, prev_rdata);
            end
            if (go)
                $display("[TB] rnd%0d we=%0d addr=%h be=%h wdata=%h", n, we, addr, be, wdata);
            prev_valid = go; prev_err = cur_err; prev_rdata = cur_rdata;
            @(posedge clk); #1;
        end
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        @(negedge clk);
        check("rnd_tail.rvalid", 32'(rvalid), 32'(prev_valid));
        if (prev_valid) begin
            check("rnd_tail.err", 32'(bus_err), 32'(prev_err));
            check("rnd_tail.rdata", rdata, prev_rdata);
        end
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
